// File: rtl/pulse_burst_generator_pkg.sv
// Package: pulse_burst_generator_pkg
// Purpose: default sizing shared by the burst generator and its gap counter.
//   State encodings and zero/one constants are deliberately kept inside the
//   modules that use them; only the default widths are shared here.
package pulse_burst_generator_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH    = 16;
  localparam int unsigned DEFAULT_PENDING_WIDTH = 4;

endpackage : pulse_burst_generator_pkg

// File: rtl/pulse_burst_generator_counter.sv
// Module: pulse_burst_generator_counter
// Purpose: gap down-counter between burst pulses. Loads a new value when a
//   pulse is emitted and otherwise counts down until it reaches zero, where
//   it holds.
// Ports:
//   clock      in   single clock, rising edge
//   reset      in   asynchronous active-high clear
//   load       in   load load_value this edge (has priority over counting)
//   load_value in   value to load
//   value      out  current count
//   is_zero    out  combinational flag, value == 0
module pulse_burst_generator_counter
  import pulse_burst_generator_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             is_zero
);

  assign is_zero = (value == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (!is_zero) begin
      value <= value - WIDTH'(1);
    end
  end

endmodule : pulse_burst_generator_counter

// File: rtl/pulse_burst_generator.sv
// Module: pulse_burst_generator
// Purpose: each accepted trigger emits burst_length single-cycle pulses spaced
//   burst_period cycles apart (period 0 acts as 1). Triggers arriving while a
//   burst runs are counted in a saturating pending counter and replayed in
//   order, keeping exactly one period between the last pulse of one burst and
//   the first pulse of the next.
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   asynchronous active-high; clears all state
//   trigger_in     in   one trigger per cycle while high
//   burst_length   in   pulses per burst, sampled at burst start
//   burst_period   in   cycles between pulses, sampled at burst start
//   pulse_out      out  registered burst pulses
//   busy           out  registered; high during a burst and its final gap
//   pending_count  out  queued triggers not yet started
//   overflow       out  registered one-cycle pulse: trigger dropped, queue full
//   state_dbg      out  current FSM state (0 = IDLE, 1 = ACTIVE)
//
// Handshake: trigger_in is a valid-only strobe with no ready. Every high
//   cycle is one trigger; it either starts a burst, is queued, is ignored
//   (burst_length 0 while idle) or is dropped and reported on overflow.
module pulse_burst_generator
  import pulse_burst_generator_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = DEFAULT_WORD_WIDTH,
  parameter int unsigned PENDING_WIDTH = DEFAULT_PENDING_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     trigger_in,
  input  logic [WORD_WIDTH-1:0]    burst_length,
  input  logic [WORD_WIDTH-1:0]    burst_period,
  output logic                     pulse_out,
  output logic                     busy,
  output logic [PENDING_WIDTH-1:0] pending_count,
  output logic                     overflow,
  output logic                     state_dbg
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                  state;
  logic [WORD_WIDTH-1:0]   remaining;
  logic [WORD_WIDTH-1:0]   p_lat;
  logic [WORD_WIDTH-1:0]   gap;
  logic                    gap_zero;

  logic [WORD_WIDTH-1:0]   p_eff;
  logic                    start;       // a burst entry is consumed this edge
  logic                    start_pulse; // ... and it has at least one pulse
  logic                    from_queue;  // the consumed entry came from pending
  logic                    reload;      // next pulse of the running burst
  logic                    go_idle;
  logic                    queue_trig;  // trigger_in must go to the queue
  logic                    pending_inc;
  logic                    drop;
  logic                    gap_load;
  logic [WORD_WIDTH-1:0]   gap_load_value;

  assign state_dbg = state;
  assign p_eff     = (burst_period == '0) ? WORD_WIDTH'(1) : burst_period;

  always_comb begin
    start      = 1'b0;
    from_queue = 1'b0;
    reload     = 1'b0;
    go_idle    = 1'b0;
    queue_trig = 1'b0;
    case (state)
      IDLE: begin
        // A zero-length request while idle is ignored outright.
        start = trigger_in && (burst_length != '0);
      end
      ACTIVE: begin
        if (!gap_zero) begin
          queue_trig = trigger_in;
        end else if (remaining != '0) begin
          reload     = 1'b1;
          queue_trig = trigger_in;
        end else if (pending_count != '0) begin
          start      = 1'b1;
          from_queue = 1'b1;
          queue_trig = trigger_in;
        end else if (trigger_in) begin
          start = 1'b1;
        end else begin
          go_idle = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    // A zero-length entry is consumed without a pulse; the gap stays 0 so
    // the next cycle re-evaluates the queue.
    start_pulse = start && (burst_length != '0);

    // Dequeue on the same edge frees a slot, so a full queue only drops when
    // nothing is being taken out.
    drop        = queue_trig && (&pending_count) && !from_queue;
    pending_inc = queue_trig && !drop;

    gap_load       = start_pulse || reload;
    gap_load_value = start_pulse ? (p_eff - WORD_WIDTH'(1))
                                 : (p_lat - WORD_WIDTH'(1));
  end

  pulse_burst_generator_counter #(
    .WIDTH(WORD_WIDTH)
  ) u_gap_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (gap_load),
    .load_value (gap_load_value),
    .value      (gap),
    .is_zero    (gap_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pulse_out     <= 1'b0;
      busy          <= 1'b0;
      pending_count <= '0;
      overflow      <= 1'b0;
      remaining     <= '0;
      p_lat         <= '0;
    end else begin
      pulse_out <= start_pulse || reload;
      overflow  <= drop;

      if (pending_inc && !from_queue) begin
        pending_count <= pending_count + PENDING_WIDTH'(1);
      end else if (from_queue && !pending_inc) begin
        pending_count <= pending_count - PENDING_WIDTH'(1);
      end

      if (start) begin
        state <= ACTIVE;
        busy  <= 1'b1;
        if (start_pulse) begin
          remaining <= burst_length - WORD_WIDTH'(1);
          p_lat     <= p_eff;
        end else begin
          remaining <= '0;
        end
      end else if (reload) begin
        remaining <= remaining - WORD_WIDTH'(1);
      end else if (go_idle) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule : pulse_burst_generator

// File: tb/tb_pulse_burst_generator.sv
// Testbench for pulse_burst_generator. Drivers push the absolute cycle of each
// expected pulse into exp_q; a monitor pops and compares on every pulse seen.
// Status outputs are compared at chosen cycles against hand-computed values.
module tb_pulse_burst_generator;

  localparam int W  = 16;
  localparam int PW = 2;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          trigger_in = 1'b0;
  logic [W-1:0]  burst_length = '0;
  logic [W-1:0]  burst_period = '0;
  logic          pulse_out;
  logic          busy;
  logic [PW-1:0] pending_count;
  logic          overflow;
  logic          state_dbg;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  pulse_burst_generator #(
    .WORD_WIDTH   (W),
    .PENDING_WIDTH(PW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .trigger_in   (trigger_in),
    .burst_length (burst_length),
    .burst_period (burst_period),
    .pulse_out    (pulse_out),
    .busy         (busy),
    .pending_count(pending_count),
    .overflow     (overflow),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int t0       = 0;

  always @(negedge clock) begin
    if (!reset && pulse_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pulse: unexpected pulse at cycle %0d, none expected", cyc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (e != 32'(cyc)) begin
          failures++;
          $display("FAIL pulse: got pulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < t0 + n) step();
  endtask

  task automatic begin_test();
    step();
    t0 = cyc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task automatic expect_pulses(input int first, input int period, input int count);
    for (int k = 0; k < count; k++) exp_q.push_back(32'(t0 + first + k * period));
  endtask

  task automatic drain_check(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    check("reset_pulse", 32'(pulse_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pending", 32'(pending_count), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    step();

    // 1: L=3 P=4 -> pulses 1,5,9; busy low from 13
    begin_test();
    burst_length = 16'd3; burst_period = 16'd4; trigger_in = 1'b1;
    expect_pulses(1, 4, 3);
    step(); trigger_in = 1'b0;
    check("t1_state_active", 32'(state_dbg), 32'd1);
    goto(12); check("t1_busy_12", 32'(busy), 32'd1);
    goto(13); check("t1_busy_13", 32'(busy), 32'd0);
    check("t1_pending", 32'(pending_count), 32'd0);
    drain_check("t1_drain");

    // 2: L=3 P=0 -> pulses 1,2,3; busy low from 4
    begin_test();
    burst_length = 16'd3; burst_period = 16'd0; trigger_in = 1'b1;
    expect_pulses(1, 1, 3);
    step(); trigger_in = 1'b0;
    goto(3); check("t2_busy_3", 32'(busy), 32'd1);
    goto(4); check("t2_busy_4", 32'(busy), 32'd0);
    drain_check("t2_drain");

    // 3: L=2 P=3, triggers 0 and 2 -> pulses 1,4,7,10
    begin_test();
    burst_length = 16'd2; burst_period = 16'd3; trigger_in = 1'b1;
    expect_pulses(1, 3, 4);
    step(); trigger_in = 1'b0;
    goto(2); trigger_in = 1'b1;
    step(); trigger_in = 1'b0;
    check("t3_pending_3", 32'(pending_count), 32'd1);
    goto(8); check("t3_pending_8", 32'(pending_count), 32'd0);
    goto(12); check("t3_busy_12", 32'(busy), 32'd1);
    goto(13); check("t3_busy_13", 32'(busy), 32'd0);
    drain_check("t3_drain");

    // 4: L=4 P=8, trigger 0 then 2..5 -> saturate at 3, overflow at 6, 16 pulses
    begin_test();
    burst_length = 16'd4; burst_period = 16'd8; trigger_in = 1'b1;
    expect_pulses(1, 8, 16);
    step(); trigger_in = 1'b0;
    goto(2); trigger_in = 1'b1;
    goto(5); check("t4_pending_5", 32'(pending_count), 32'd3);
    check("t4_overflow_5", 32'(overflow), 32'd0);
    goto(6); trigger_in = 1'b0;
    check("t4_overflow_6", 32'(overflow), 32'd1);
    check("t4_pending_6", 32'(pending_count), 32'd3);
    goto(7); check("t4_overflow_7", 32'(overflow), 32'd0);
    goto(128); check("t4_busy_128", 32'(busy), 32'd1);
    goto(129); check("t4_busy_129", 32'(busy), 32'd0);
    check("t4_pending_end", 32'(pending_count), 32'd0);
    drain_check("t4_drain");

    // 5: L=5 P=2, triggers 0 and 2, reset during cycles 4-5 -> pulses 1,3 only
    begin_test();
    burst_length = 16'd5; burst_period = 16'd2; trigger_in = 1'b1;
    expect_pulses(1, 2, 2);
    step(); trigger_in = 1'b0;
    goto(2); trigger_in = 1'b1;
    step(); trigger_in = 1'b0;
    check("t5_pending_3", 32'(pending_count), 32'd1);
    goto(4); reset = 1'b1;
    #1;
    check("t5_rst_pulse", 32'(pulse_out), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_pending", 32'(pending_count), 32'd0);
    check("t5_rst_overflow", 32'(overflow), 32'd0);
    goto(6); reset = 1'b0;
    drain_check("t5_drain_reset");
    begin_test();
    burst_length = 16'd1; burst_period = 16'd1; trigger_in = 1'b1;
    expect_pulses(1, 1, 1);
    step(); trigger_in = 1'b0;
    check("t5_fresh_busy_1", 32'(busy), 32'd1);
    goto(2); check("t5_fresh_busy_2", 32'(busy), 32'd0);
    check("t5_fresh_pending", 32'(pending_count), 32'd0);
    drain_check("t5_drain_fresh");

    // 6a: L=0 in IDLE -> ignored
    begin_test();
    burst_length = 16'd0; burst_period = 16'd1; trigger_in = 1'b1;
    step(); trigger_in = 1'b0;
    check("t6_l0_busy", 32'(busy), 32'd0);
    check("t6_l0_pending", 32'(pending_count), 32'd0);
    goto(3); check("t6_l0_busy_3", 32'(busy), 32'd0);

    // 6b: L changed 2->6 mid-burst -> still 2 pulses at 1,3; busy low from 5
    begin_test();
    burst_length = 16'd2; burst_period = 16'd2; trigger_in = 1'b1;
    expect_pulses(1, 2, 2);
    step(); trigger_in = 1'b0; burst_length = 16'd6;
    goto(4); check("t6_busy_4", 32'(busy), 32'd1);
    goto(5); check("t6_busy_5", 32'(busy), 32'd0);
    goto(12); drain_check("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pulse_burst_generator
